// File: rtl/nn_pkg.sv
// Shared types and sizing for the accelerator read-out path.
package nn_pkg;
  localparam int N_CLASSES = 10;
  localparam int DATA_W    = 16;

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    STREAM
  } rr_state_t;

  typedef logic [3:0] class_idx_t;
endpackage

// File: rtl/result_reader_argmax_step.sv
// One argmax step: keep the running best unless the candidate is strictly greater (signed).
module argmax_step #(
  parameter int DATA_W = 16,
  parameter int IDX_W  = 4
) (
  input  logic                     init,
  input  logic signed [DATA_W-1:0] cand_val,
  input  logic        [IDX_W-1:0]  cand_idx,
  input  logic signed [DATA_W-1:0] best_val,
  input  logic        [IDX_W-1:0]  best_idx,
  output logic signed [DATA_W-1:0] next_val,
  output logic        [IDX_W-1:0]  next_idx
);
  // Strict greater-than keeps the lower index on ties.
  always_comb begin
    next_val = best_val;
    next_idx = best_idx;
    if (init || (cand_val > best_val)) begin
      next_val = cand_val;
      next_idx = cand_idx;
    end
  end
endmodule

// File: rtl/result_reader.sv
// Captures the class scores on start, finds the argmax one class per cycle,
// then streams the raw scores out over valid/ready.
module result_reader
  import nn_pkg::*;
#(
  parameter int N_CLASSES = nn_pkg::N_CLASSES,
  parameter int DATA_W    = nn_pkg::DATA_W
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          start,
  input  logic [N_CLASSES*DATA_W-1:0]   scores,
  output logic                          busy,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [DATA_W-1:0]             out_data,
  output logic [3:0]                    out_index,
  output logic                          out_last,
  output logic [3:0]                    class_id,
  output logic                          class_valid
);
  localparam class_idx_t LAST_IDX = class_idx_t'(N_CLASSES - 1);

  rr_state_t                 state_q;
  class_idx_t                idx_q;
  logic signed [DATA_W-1:0]  buf_q [N_CLASSES];
  logic signed [DATA_W-1:0]  best_val_q;
  class_idx_t                best_idx_q;
  class_idx_t                class_id_q;
  logic                      class_valid_q;

  logic signed [DATA_W-1:0]  best_val_d;
  class_idx_t                best_idx_d;

  argmax_step #(
    .DATA_W (DATA_W),
    .IDX_W  (4)
  ) u_step (
    .init     (idx_q == '0),
    .cand_val (buf_q[idx_q]),
    .cand_idx (idx_q),
    .best_val (best_val_q),
    .best_idx (best_idx_q),
    .next_val (best_val_d),
    .next_idx (best_idx_d)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      idx_q         <= '0;
      best_val_q    <= '0;
      best_idx_q    <= '0;
      class_id_q    <= '0;
      class_valid_q <= 1'b0;
      for (int k = 0; k < N_CLASSES; k++) buf_q[k] <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            for (int k = 0; k < N_CLASSES; k++) buf_q[k] <= scores[k*DATA_W +: DATA_W];
            class_valid_q <= 1'b0;
            idx_q         <= '0;
            state_q       <= SCAN;
          end
        end
        SCAN: begin
          best_val_q <= best_val_d;
          best_idx_q <= best_idx_d;
          if (idx_q == LAST_IDX) begin
            class_id_q    <= best_idx_d;
            class_valid_q <= 1'b1;
            idx_q         <= '0;
            state_q       <= STREAM;
          end else begin
            idx_q <= idx_q + 1'b1;
          end
        end
        STREAM: begin
          if (out_ready) begin
            if (idx_q == LAST_IDX) begin
              idx_q   <= '0;
              state_q <= IDLE;
            end else begin
              idx_q <= idx_q + 1'b1;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Stream outputs decode straight from state and index, so out_ready never reaches out_valid.
  always_comb begin
    busy      = (state_q != IDLE);
    out_valid = (state_q == STREAM);
    out_data  = out_valid ? buf_q[idx_q] : '0;
    out_index = out_valid ? idx_q : '0;
    out_last  = out_valid && (idx_q == LAST_IDX);
  end

  assign class_id    = class_id_q;
  assign class_valid = class_valid_q;
endmodule
